dot_int_acc: RTL and testbench

DOT_INT_ACC -- requirements
Module: dot_int_acc

---
 rtl/dot_int_acc.sv | 164 ++++++++++++++++
 tb/tb_dot_int_acc.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_int_acc.sv
// dot_int_acc -- streaming signed integer dot-product accumulator.
//
// Each accepted beat carries LANES pairs of signed IDATA_WIDTH elements. The
// block multiplies lane-wise, sums the products and accumulates the beat sums
// across a vector. The vector is delimited by in_last. When the final beat has
// been accumulated, the vector result is presented on the output port.
//
// Pipeline:
//   stage 1 : LANES registered products (2*IDATA_WIDTH bits each)
//   stage 2 : registered full-precision sum of the products
//   stage 3 : accumulator, sticky overflow flag, result register
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both 1. A producer holds valid and its data steady until that edge.
// Here the output register is the only point of backpressure. While a result
// is held (out_valid=1, out_ready=0), every stage freezes and in_ready is 0.
//
// Ports:
//   clk, rst        sole clock; synchronous active-high reset
//   in_valid/ready  input beat handshake, in_last marks the final beat
//   in_dataA/B      packed signed elements, lane i at [i*IDATA_WIDTH +: IDATA_WIDTH]
//   out_valid/ready result handshake
//   out_data        signed dot-product result (ACC_WIDTH bits)
//   out_ovf         an accumulate in this result's vector overflowed
module dot_int_acc #(
  parameter int LANES       = 4,
  parameter int IDATA_WIDTH = 8,
  parameter int ACC_WIDTH   = 32,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [LANES*IDATA_WIDTH-1:0] in_dataA,
  input  logic [LANES*IDATA_WIDTH-1:0] in_dataB,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_data,
  output logic                         out_ovf
);

  localparam int LG = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int PW = 2 * IDATA_WIDTH;
  localparam int SW = PW + LG;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic stall;
  logic accept;

  // Stage 1 registers
  logic                 s1_valid;
  logic                 s1_last;
  logic signed [PW-1:0] s1_prod [LANES];

  // Stage 2 registers
  logic                 s2_valid;
  logic                 s2_last;
  logic signed [SW-1:0] s2_sum;

  // Stage 3 state
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        sticky;
  logic                        first;

  // Combinational next values
  logic signed [PW-1:0]        prod_c [LANES];
  logic signed [SW-1:0]        sum_c;
  logic signed [ACC_WIDTH-1:0] ext_c;
  logic signed [ACC_WIDTH-1:0] add_c;
  logic                        add_ovf;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic                        sticky_nxt;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = $signed(in_dataA[i*IDATA_WIDTH +: IDATA_WIDTH]) *
                  $signed(in_dataB[i*IDATA_WIDTH +: IDATA_WIDTH]);
    end
  end

  // The sum width has log2(LANES) guard bits, so no term can overflow it.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + SW'(s1_prod[i]);
    end
  end

  // A first beat loads the sign-extended sum. That value always fits, so only
  // later beats can overflow. An add overflows when both operands share a sign
  // and the result has the other sign. Saturation picks the clamp value from
  // the operand sign.
  always_comb begin
    ext_c   = ACC_WIDTH'(s2_sum);
    add_c   = acc + ext_c;
    add_ovf = (acc[ACC_WIDTH-1] == ext_c[ACC_WIDTH-1]) &&
              (add_c[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    if (first) begin
      acc_nxt    = ext_c;
      sticky_nxt = 1'b0;
    end else begin
      if (add_ovf && SATURATE) begin
        acc_nxt = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_nxt = add_c;
      end
      sticky_nxt = sticky | add_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
      end
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_sum    <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_last <= in_last;
        for (int i = 0; i < LANES; i++) begin
          s1_prod[i] <= prod_c[i];
        end
      end

      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_sum   <= sum_c;

      if (s2_valid) begin
        acc    <= acc_nxt;
        sticky <= sticky_nxt;
        first  <= s2_last;
        if (s2_last) begin
          out_data <= acc_nxt;
          out_ovf  <= sticky_nxt;
        end
      end

      // Without a stall, any held result was consumed on this edge. A newly
      // completed vector keeps the valid bit set.
      out_valid <= s2_valid & s2_last;
    end
  end

endmodule

// File: tb/tb_dot_int_acc.sv
// Testbench for dot_int_acc.
// Three instances share one input stream: the default 32-bit saturating
// configuration, a 20-bit saturating one and a 20-bit wrapping one.
module tb_dot_int_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_dataA;
  logic [31:0] in_dataB;
  logic        out_ready;

  logic        ir32, ov32, of32;
  logic [31:0] od32;
  logic        ir20s, ov20s, of20s;
  logic [19:0] od20s;
  logic        ir20w, ov20w, of20w;
  logic [19:0] od20w;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit directed_mode = 1'b0;
  bit rand_ready    = 1'b0;

  logic [32:0] exp32_q[$];
  logic [20:0] exp20s_q[$];
  logic [20:0] exp20w_q[$];

  dot_int_acc u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .in_last(in_last),
    .in_dataA(in_dataA), .in_dataB(in_dataB), .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .out_ovf(of32)
  );

  dot_int_acc #(.ACC_WIDTH(20), .SATURATE(1'b1)) u20s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir20s), .in_last(in_last),
    .in_dataA(in_dataA), .in_dataB(in_dataB), .out_valid(ov20s), .out_ready(out_ready),
    .out_data(od20s), .out_ovf(of20s)
  );

  dot_int_acc #(.ACC_WIDTH(20), .SATURATE(1'b0)) u20w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir20w), .in_last(in_last),
    .in_dataA(in_dataA), .in_dataB(in_dataB), .out_valid(ov20w), .out_ready(out_ready),
    .out_data(od20w), .out_ovf(of20w)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
    pk = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [32:0] mk32(input longint d, input bit o);
    mk32 = {o, 32'(d)};
  endfunction

  function automatic logic [20:0] mk20(input longint d, input bit o);
    mk20 = {o, 20'(d)};
  endfunction

  task automatic check(input string nm, input longint got_d, input bit got_o,
                       input longint exp_d, input bit exp_o);
    n_vec++;
    if (got_d != exp_d || got_o != exp_o) begin
      n_bad++;
      $display("FAIL %s: got data=%0d ovf=%0b, expected data=%0d ovf=%0b", nm, got_d, got_o, exp_d, exp_o);
    end
  endtask

  task automatic check_val(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The model accumulates in 64-bit integers. It flags a result that leaves
  // the signed range of the width, then clamps or wraps that result.
  longint m_acc32, m_acc20s, m_acc20w;
  bit     m_o32, m_o20s, m_o20w;
  bit     m_first = 1'b1;

  function automatic longint fold(input longint t, input int w, input bit sat, output bit ovf);
    longint mx, mn, r;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -(longint'(1) <<< (w - 1));
    ovf = (t > mx) || (t < mn);
    if (!ovf) r = t;
    else if (sat) r = (t > mx) ? mx : mn;
    else begin
      r = t & ((longint'(1) <<< w) - 1);
      if (r > mx) r = r - (longint'(1) <<< w);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_first = 1'b1;
    end else if (in_valid && ir32) begin
      longint dot;
      bit o;
      dot = 0;
      for (int i = 0; i < 4; i++) begin
        dot += longint'($signed(in_dataA[i*8 +: 8])) * longint'($signed(in_dataB[i*8 +: 8]));
      end
      if (m_first) begin
        m_acc32 = dot; m_acc20s = dot; m_acc20w = dot;
        m_o32 = 1'b0; m_o20s = 1'b0; m_o20w = 1'b0;
      end else begin
        m_acc32  = fold(m_acc32 + dot, 32, 1'b1, o);  m_o32  |= o;
        m_acc20s = fold(m_acc20s + dot, 20, 1'b1, o); m_o20s |= o;
        m_acc20w = fold(m_acc20w + dot, 20, 1'b0, o); m_o20w |= o;
      end
      if (in_last && !directed_mode) begin
        exp32_q.push_back(mk32(m_acc32, m_o32));
        exp20s_q.push_back(mk20(m_acc20s, m_o20s));
        exp20w_q.push_back(mk20(m_acc20w, m_o20w));
      end
      m_first = in_last;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [32:0] e33;
      logic [20:0] e21;
      if (ov32 && out_ready) begin
        if (exp32_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL r32_unexpected: got result %0d with empty expected queue", $signed(od32));
        end else begin
          e33 = exp32_q.pop_front();
          check("r32", longint'($signed(od32)), of32, longint'($signed(e33[31:0])), e33[32]);
        end
      end
      if (ov20s && out_ready) begin
        if (exp20s_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL r20s_unexpected: got result %0d with empty expected queue", $signed(od20s));
        end else begin
          e21 = exp20s_q.pop_front();
          check("r20s", longint'($signed(od20s)), of20s, longint'($signed(e21[19:0])), e21[20]);
        end
      end
      if (ov20w && out_ready) begin
        if (exp20w_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL r20w_unexpected: got result %0d with empty expected queue", $signed(od20w));
        end else begin
          e21 = exp20w_q.pop_front();
          check("r20w", longint'($signed(od20w)), of20w, longint'($signed(e21[19:0])), e21[20]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    bit done;
    in_dataA = a; in_dataB = b; in_last = last; in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (ir32) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL beat_timeout: in_ready stayed 0 for 200 cycles, expected 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_all(input logic [32:0] e32, input logic [20:0] e20s, input logic [20:0] e20w);
    exp32_q.push_back(e32); exp20s_q.push_back(e20s); exp20w_q.push_back(e20w);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp32_q.size() + exp20s_q.size() + exp20w_q.size()) != 0 && t < 300) begin
      idle(1); t++;
    end
    check_val("queues_drained", exp32_q.size() + exp20s_q.size() + exp20w_q.size(), 0);
  endtask

  task automatic check_reset_state(input string nm);
    @(negedge clk);
    check_val({nm, "_out_valid"}, ov32, 0);
    check_val({nm, "_in_ready"}, ir32, 1);
    check(nm, longint'($signed(od32)), of32, 0, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          beats;
    logic [32:0] e32;
    logic [20:0] e20s;
    logic [20:0] e20w;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] a70, b70, ones, m128;
    int c0;

    a70  = pk(1, 2, 3, 4);
    b70  = pk(5, 6, 7, 8);
    ones = pk(1, 1, 1, 1);
    m128 = pk(-128, -128, -128, -128);

    tbl[0] = '{a70, b70, 1, mk32(70, 0), mk20(70, 0), mk20(70, 0)};
    tbl[1] = '{pk(127, -1, 0, -128), pk(-1, -1, 5, 1), 1,
               mk32(-254, 0), mk20(-254, 0), mk20(-254, 0)};
    tbl[2] = '{m128, m128, 3, mk32(196608, 0), mk20(196608, 0), mk20(196608, 0)};
    tbl[3] = '{m128, m128, 8, mk32(524288, 0), mk20(524287, 1), mk20(-524288, 1)};
    tbl[4] = '{ones, ones, 1, mk32(4, 0), mk20(4, 0), mk20(4, 0)};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_dataA = '0; in_dataB = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Latency: accepted at edge k, result visible after edge k+2.
    directed_mode = 1'b1;
    push_all(mk32(70, 0), mk20(70, 0), mk20(70, 0));
    send_beat(a70, b70, 1'b1);
    check_val("lat_k", ov32, 0);
    idle(1);
    check_val("lat_k1", ov32, 0);
    idle(1);
    check_val("lat_k2", ov32, 1);
    drain();

    // Table vectors under random output backpressure.
    rand_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      push_all(tbl[v].e32, tbl[v].e20s, tbl[v].e20w);
      for (int j = 0; j < tbl[v].beats; j++) begin
        send_beat(tbl[v].a, tbl[v].b, j == tbl[v].beats - 1);
      end
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0; out_ready = 1'b1;
    drain();

    // Held result: 70 stays put with in_ready low, then 4 follows.
    out_ready = 1'b0;
    push_all(mk32(70, 0), mk20(70, 0), mk20(70, 0));
    push_all(mk32(4, 0), mk20(4, 0), mk20(4, 0));
    send_beat(a70, b70, 1'b1);
    send_beat(ones, ones, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("hold_valid", ov32, 1);
      check_val("hold_in_ready", ir32, 0);
      check_val("hold_data", longint'($signed(od32)), 70);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Back-to-back single-beat vectors: one beat per cycle.
    directed_mode = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) send_beat($urandom(), $urandom(), 1'b1);
    check_val("b2b_cycles", cyc - c0, 4);
    drain();

    // Reset mid-vector discards the partial sum.
    directed_mode = 1'b1;
    send_beat(a70, b70, 1'b0);
    send_beat(a70, b70, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    check_reset_state("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    push_all(mk32(4, 0), mk20(4, 0), mk20(4, 0));
    send_beat(ones, ones, 1'b1);
    drain();

    // Random vectors, random gaps, random backpressure.
    directed_mode = 1'b0;
    rand_ready = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        send_beat($urandom(), $urandom(), j == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_ready = 1'b0; out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
